// File: rtl/fetch_ctrl_if.sv
// Fetch-sequencer bus: ROM address/data, branch redirect and decode handshake.
// The master side is the fetch sequencer; the slave side is ROM, branch unit and decode.
interface fetch_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              if_valid;
  logic              if_ready;
  logic [31:0]       if_inst;
  logic [ADDR_W-1:0] if_pc;
  logic              halted;

  modport master (
    output rom_addr,
    input  rom_data,
    input  br_valid,
    input  br_target,
    output if_valid,
    input  if_ready,
    output if_inst,
    output if_pc,
    output halted
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output br_valid,
    output br_target,
    input  if_valid,
    output if_ready,
    input  if_inst,
    input  if_pc,
    input  halted
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues PCs to a registered ROM, queues words for decode.
// Optional FETCH_PERF_EN adds saturating fetched/flushed performance counters.
module fetch_ctrl #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       ROM_DEPTH = 7,
  parameter int unsigned       QDEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]  perf_fetched,
  output logic [15:0]  perf_flushed
`endif
);

  localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CntW = $clog2(QDEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              kill_q, kill_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]       mem_inst_q [QDEPTH];
  logic [ADDR_W-1:0] mem_pc_q   [QDEPTH];

  logic              has_head;
  logic              pop;
  logic              capture;
  logic              issue;
  logic              in_range;
  logic [ADDR_W-1:0] word_idx;
  logic [CntW:0]     occupancy;
  logic              unused_tgt;

  assign unused_tgt = ^bus.br_target[1:0];

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(QDEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign word_idx = fetch_pc_q >> 2;
  assign in_range = (ADDR_W + 32)'(word_idx) < (ADDR_W + 32)'(ROM_DEPTH);
  assign has_head = (count_q != '0);

  assign bus.rom_addr = fetch_pc_q;
  assign bus.if_valid = has_head & ~bus.br_valid;
  assign bus.if_inst  = has_head ? mem_inst_q[rd_ptr_q] : '0;
  assign bus.if_pc    = has_head ? mem_pc_q[rd_ptr_q] : '0;
  assign bus.halted   = ~in_range & ~has_head & ~inflight_q;

  assign pop = bus.if_valid & bus.if_ready;

  // Slots already committed after this edge: queued + in flight, minus the word leaving.
  assign occupancy = {1'b0, count_q} + (CntW + 1)'(inflight_q) - (CntW + 1)'(pop);
  assign issue     = in_range & ~bus.br_valid & (occupancy < (CntW + 1)'(QDEPTH));

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    kill_d        = 1'b0;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    capture       = 1'b0;
    if (bus.br_valid) begin
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      kill_d     = inflight_q;
      fetch_pc_d = {bus.br_target[ADDR_W-1:2], 2'b00};
    end else begin
      capture = inflight_q & ~kill_q;
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
      end
      if (capture) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CntW'(capture) - CntW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(QDEPTH); i++) begin
        mem_inst_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else if (capture) begin
      mem_inst_q[wr_ptr_q] <= bus.rom_data;
      mem_pc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [16:0] fetched_sum;
  logic [16:0] flushed_sum;

  assign fetched_sum = {1'b0, perf_fetched} + 17'(pop);
  assign flushed_sum = {1'b0, perf_flushed} + 17'(count_q) + 17'(inflight_q & ~kill_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= fetched_sum[16] ? 16'hFFFF : fetched_sum[15:0];
      if (bus.br_valid) perf_flushed <= flushed_sum[16] ? 16'hFFFF : flushed_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl against a queue-based behavioural model,
// plus directed scenarios with literal expectations.
module tb_fetch_ctrl;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned ROM_DEPTH = 7;
  localparam int unsigned QDEPTH    = 2;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_flushed;
`endif

  fetch_ctrl #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC),
    .ROM_DEPTH(ROM_DEPTH),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_flushed(perf_flushed)
`endif
  );

  logic [31:0] rom [ROM_DEPTH];
  initial begin
    rom[0] = 32'hE3A02005; rom[1] = 32'hE3A01001; rom[2] = 32'hE0812002;
    rom[3] = 32'hE2522001; rom[4] = 32'h1AFFFFFC; rom[5] = 32'hE5801000;
    rom[6] = 32'hEAFFFFFE;
  end

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = a >> 2;
    return (idx < ROM_DEPTH) ? rom[idx] : 32'hDEADBEEF;
  endfunction

  // Registered ROM; its reset follows the fetch reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) bus.rom_data <= '0;
    else      bus.rom_data <= rom_word(bus.rom_addr);
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  bit          m_infl;
  int          m_fetched;
  int          m_flushed;

  function automatic void m_reset();
    mq.delete();
    m_pc      = RESET_PC;
    m_ipc     = '0;
    m_infl    = 1'b0;
    m_fetched = 0;
    m_flushed = 0;
  endfunction

  function automatic bit m_in_range();
    return (m_pc >> 2) < ROM_DEPTH;
  endfunction

  function automatic void m_step(input bit rdy, input bit br, input logic [31:0] tgt);
    bit   pop;
    bit   iss;
    int   occ;
    ent_t e;
    if (br) begin
      m_flushed = m_flushed + mq.size() + int'(m_infl);
      if (m_flushed > 65535) m_flushed = 65535;
      mq.delete();
      m_infl = 1'b0;
      m_pc   = tgt & ~32'h3;
      return;
    end
    pop = (mq.size() != 0) && rdy;
    occ = mq.size() + int'(m_infl) - int'(pop);
    iss = m_in_range() && (occ < int'(QDEPTH));
    if (pop) begin
      void'(mq.pop_front());
      if (m_fetched < 65535) m_fetched++;
    end
    if (m_infl) begin
      e.pc   = m_ipc;
      e.inst = rom_word(m_ipc);
      mq.push_back(e);
    end
    m_infl = iss;
    if (iss) begin
      m_ipc = m_pc;
      m_pc  = m_pc + 32'd4;
    end
  endfunction

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare_all(input bit br);
    bit exp_valid;
    exp_valid = (mq.size() != 0) && !br;
    chk("if_valid", 32'(bus.if_valid), 32'(exp_valid));
    if (exp_valid) begin
      chk("if_pc", bus.if_pc, mq[0].pc);
      chk("if_inst", bus.if_inst, mq[0].inst);
    end
    chk("halted", 32'(bus.halted),
        32'(!m_in_range() && (mq.size() == 0) && !m_infl));
    chk("rom_addr", bus.rom_addr, m_pc);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", 32'(perf_fetched), 32'(m_fetched));
    chk("perf_flushed", 32'(perf_flushed), 32'(m_flushed));
`endif
  endtask

  logic [31:0] popped[$];
  int          popped_cyc[$];
  int          cyc;

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step(input bit rdy, input bit br, input logic [31:0] tgt);
    bus.if_ready  = rdy;
    bus.br_valid  = br;
    bus.br_target = tgt;
    #1;
    compare_all(br);
    if (bus.if_valid && rdy) begin
      popped.push_back(bus.if_pc);
      popped_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (rst) m_step(rdy, br, tgt);
    else     m_reset();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.if_ready  = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_target = '0;
    repeat (2) @(negedge clk);
    m_reset();
    #1;
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_inst", bus.if_inst, 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_rom_addr", bus.rom_addr, RESET_PC);
    @(negedge clk);
    rst = 1'b1;
    popped.delete();
    popped_cyc.delete();
    cyc = 0;
  endtask

  initial begin
    bit          seen_c;
    int          n;
    logic [31:0] tgt;

    // 1: free-running fetch to the end of the ROM image
    do_reset();
    repeat (12) step(1'b1, 1'b0, '0);
    chk("t1_pop_count", 32'(popped.size()), 32'd7);
    for (int i = 0; i < popped.size(); i++) chk("t1_pc_seq", popped[i], 32'(4 * i));
    if (popped_cyc.size() == 7) begin
      chk("t1_first_pop_cyc", 32'(popped_cyc[0]), 32'd2);
      chk("t1_last_pop_cyc", 32'(popped_cyc[6]), 32'd8);
    end
    chk("t1_halted", 32'(bus.halted), 32'd1);
    chk("t1_rom_addr", bus.rom_addr, 32'd28);

    // 2: decode stall fills the queue, then resumes without gaps
    do_reset();
    repeat (6) step(1'b0, 1'b0, '0);
    #1;
    chk("t2_hold_inst", bus.if_inst, 32'hE3A02005);
    chk("t2_hold_pc", bus.if_pc, 32'd0);
    chk("t2_stop_issue", bus.rom_addr, 32'd8);
    @(negedge clk);
    repeat (10) step(1'b1, 1'b0, '0);
    chk("t2_pop_count", 32'(popped.size()), 32'd7);
    for (int i = 0; i < popped.size(); i++) chk("t2_pc_seq", popped[i], 32'(4 * i));

    // 3: redirect while pc 8 is at the head
    do_reset();
    n = 0;
    while (!(mq.size() != 0 && mq[0].pc == 32'd8) && n < 20) begin
      step(1'b1, 1'b0, '0);
      n++;
    end
    chk("t3_reached_pc8", 32'(n < 20), 32'd1);
    step(1'b1, 1'b1, 32'h0);
    repeat (5) step(1'b1, 1'b0, '0);
    seen_c = 1'b0;
    foreach (popped[i]) if (popped[i] == 32'hC) seen_c = 1'b1;
    chk("t3_no_0xC", 32'(seen_c), 32'd0);
    if (popped.size() > 2) chk("t3_after_flush_pc", popped[2], 32'd0);
    else chk("t3_after_flush_cnt", 32'(popped.size()), 32'd3);
`ifdef FETCH_PERF_EN
    chk("t3_perf_flushed", 32'(perf_flushed), 32'd2);
    chk("t3_perf_fetched", 32'(perf_fetched), 32'(popped.size()));
`endif

    // 4: low target bits masked; out-of-range target halts; redirect restarts
    do_reset();
    step(1'b1, 1'b1, 32'h6);
    repeat (4) step(1'b1, 1'b0, '0);
    if (popped.size() > 0) chk("t4_masked_pc", popped[0], 32'd4);
    else chk("t4_masked_cnt", 32'(popped.size()), 32'd1);
    step(1'b1, 1'b1, 32'h40);
    repeat (3) step(1'b1, 1'b0, '0);
    #1;
    chk("t4_halted", 32'(bus.halted), 32'd1);
    chk("t4_rom_addr", bus.rom_addr, 32'h40);
    @(negedge clk);
    popped.delete();
    step(1'b1, 1'b1, 32'h8);
    repeat (3) step(1'b1, 1'b0, '0);
    if (popped.size() > 0) chk("t4_restart_pc", popped[0], 32'd8);
    else chk("t4_restart_cnt", 32'(popped.size()), 32'd1);
    chk("t4_left_halt", 32'(bus.halted), 32'd0);

    // 5: asynchronous reset mid-stream with a full queue
    do_reset();
    repeat (4) step(1'b0, 1'b0, '0);
    #2 rst = 1'b0;
    #1;
    m_reset();
    chk("t5_async_valid", 32'(bus.if_valid), 32'd0);
    chk("t5_async_pc", bus.if_pc, 32'd0);
    chk("t5_async_addr", bus.rom_addr, RESET_PC);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    popped.delete();
    repeat (4) step(1'b1, 1'b0, '0);
    if (popped.size() > 0) chk("t5_first_pc", popped[0], RESET_PC);
    else chk("t5_first_cnt", 32'(popped.size()), 32'd1);

    // 6: random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tgt = {$urandom_range(0, 17), 2'b00} | 32'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
